// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO push-side arbiter and its picker.
// Holds the arbitration state encoding and the modulo-N round-robin increment.
// The increment wraps at the requester count, not at a power of two.
package fifo_arb_pkg;

  // ARB: choose a new owner each cycle; LOCK: stay with owner_q for a burst.
  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  // Next index after 'last' in a ring of num_req entries.
  function automatic int unsigned rr_next(input int unsigned last,
                                          input int unsigned num_req);
    if (last + 1 >= num_req) begin
      return 0;
    end
    return last + 1;
  endfunction

endpackage

// File: rtl/fifo_push_arbiter_rr_picker.sv
// Round-robin picker: first set request after last_i, searching modulo NUM_REQ.
// Purely combinational, no state and no clock.
// When nothing is requested, winner_o falls back to last_i and any_valid_o is low.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [IDX_W-1:0]   winner_o,
  output logic               any_valid_o
);

  logic [IDX_W-1:0] idx;
  logic             found;

  // Walk the ring starting one past last_i; the first hit wins.
  always_comb begin
    winner_o    = last_i;
    any_valid_o = 1'b0;
    found       = 1'b0;
    idx         = last_i;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IDX_W'(rr_next(32'(idx), NUM_REQ));
      if (!found && req_i[idx]) begin
        found    = 1'b1;
        winner_o = idx;
      end
    end
    any_valid_o = found;
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Shares one FIFO push port among NUM_REQ requesters, round-robin with burst locking.
// Zero-latency datapath: selected data and grants are combinational; state is registered.
// A full FIFO (push_grant_i low) stalls the current selection; the burst count holds.
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  input  logic [NUM_REQ*(DATA_WIDTH+1)-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]                  req_grant_o,
  output logic                                push_valid_o,
  output logic [DATA_WIDTH:0]                 push_data_o,
  input  logic                                push_grant_i,
  output logic [$clog2(NUM_REQ)-1:0]          owner_o,
  output logic                                locked_o
);

  localparam int DW    = DATA_WIDTH + 1;
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  // Arbitration state.
  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] last_q,  last_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  // Combinational selection.
  logic [DW-1:0]    slice   [NUM_REQ];
  logic [IDX_W-1:0] winner;
  logic             any_valid;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_vld;
  logic             sel_has_data;
  logic             xfer;

  // Unpack the flat requester bus into one word per requester.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign slice[gi] = req_data_i[gi*DW +: DW];
  end

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_i       (req_valid_i),
    .last_i      (last_q),
    .winner_o    (winner),
    .any_valid_o (any_valid)
  );

  // Pick the candidate: the locked owner in LOCK, otherwise the round-robin winner.
  // With nobody requesting in ARB the index parks on last_q and the data is zeroed.
  always_comb begin
    sel_idx      = last_q;
    sel_vld      = 1'b0;
    sel_has_data = 1'b0;
    if (state_q == LOCK) begin
      sel_idx      = owner_q;
      sel_vld      = req_valid_i[owner_q];
      sel_has_data = 1'b1;
    end else if (any_valid) begin
      sel_idx      = winner;
      sel_vld      = 1'b1;
      sel_has_data = 1'b1;
    end
  end

  // Drive the FIFO and requester outputs; reset forces everything quiet
  // immediately, without waiting for the registers to settle.
  always_comb begin
    push_valid_o = 1'b0;
    push_data_o  = '0;
    owner_o      = '0;
    locked_o     = 1'b0;
    req_grant_o  = '0;
    xfer         = 1'b0;
    if (!rst) begin
      push_valid_o = sel_vld;
      owner_o      = sel_idx;
      locked_o     = (state_q == LOCK);
      if (sel_has_data) begin
        push_data_o = slice[sel_idx];
      end
      xfer = sel_vld && push_grant_i;
      if (xfer) begin
        req_grant_o[sel_idx] = 1'b1;
      end
    end
  end

  // Next-state: start a burst on an ARB transfer, count beats in LOCK, and
  // drop back to ARB when the burst is complete or the owner goes idle.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ARB: begin
        if (xfer) begin
          last_d = winner;
          cnt_d  = CNT_W'(1);
          if (MAX_BURST > 1) begin
            state_d = LOCK;
            owner_d = winner;
          end
        end
      end
      LOCK: begin
        if (!req_valid_i[owner_q]) begin
          // Owner went idle: one bubble cycle, then re-arbitrate from owner_q+1.
          state_d = ARB;
          cnt_d   = '0;
        end else if (xfer) begin
          if (cnt_q == CNT_W'(MAX_BURST - 1)) begin
            state_d = ARB;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ARB;
        cnt_d   = '0;
      end
    endcase
  end

  // State register; last_q resets to the top index so requester 0 goes first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB;
      last_q  <= IDX_W'(NUM_REQ - 1);
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Bench for fifo_push_arbiter: a 4-requester/burst-4 instance and a 3-requester/burst-1 instance.
// Directed scenarios plus a random run checked against a ring/burst model.
// Inputs change 1 time unit after posedge; outputs are sampled at negedge.
module tb_fifo_push_arbiter;

  localparam int NA  = 4;
  localparam int MBA = 4;
  localparam int DWA = 33;
  localparam int IWA = 2;
  localparam int NB  = 3;
  localparam int DWB = 8;
  localparam int IWB = 2;

  logic clk = 1'b0;
  logic rst;

  logic [NA-1:0]     vld_a;
  logic [NA*DWA-1:0] data_a;
  logic [NA-1:0]     gnt_a;
  logic              pvld_a;
  logic [DWA-1:0]    pdata_a;
  logic              fgnt_a;
  logic [IWA-1:0]    owner_a;
  logic              locked_a;

  logic [NB-1:0]     vld_b;
  logic [NB*DWB-1:0] data_b;
  logic [NB-1:0]     gnt_b;
  logic              pvld_b;
  logic [DWB-1:0]    pdata_b;
  logic              fgnt_b;
  logic [IWB-1:0]    owner_b;
  logic              locked_b;

  int total = 0;
  int bad   = 0;

  // Reference model state: ring pointer, lock flag, owner, beats remaining.
  int m_last;
  int m_owner;
  bit m_locked;
  int m_left;

  always #5 clk = ~clk;

  fifo_push_arbiter #(.DATA_WIDTH(32), .NUM_REQ(NA), .MAX_BURST(MBA)) dut_a (
    .clk(clk), .rst(rst), .req_valid_i(vld_a), .req_data_i(data_a),
    .req_grant_o(gnt_a), .push_valid_o(pvld_a), .push_data_o(pdata_a),
    .push_grant_i(fgnt_a), .owner_o(owner_a), .locked_o(locked_a)
  );

  fifo_push_arbiter #(.DATA_WIDTH(7), .NUM_REQ(NB), .MAX_BURST(1)) dut_b (
    .clk(clk), .rst(rst), .req_valid_i(vld_b), .req_data_i(data_b),
    .req_grant_o(gnt_b), .push_valid_o(pvld_b), .push_data_o(pdata_b),
    .push_grant_i(fgnt_b), .owner_o(owner_b), .locked_o(locked_b)
  );

  function automatic logic [DWA-1:0] rand_word();
    logic [63:0] w;
    w = {$urandom(), $urandom()};
    return w[DWA-1:0];
  endfunction

  function automatic logic [DWA-1:0] slice_a(input int i);
    return data_a[i*DWA +: DWA];
  endfunction

  task automatic set_slice_a(input int i, input logic [DWA-1:0] v);
    data_a[i*DWA +: DWA] = v;
  endtask

  task automatic model_reset();
    m_last   = NA - 1;
    m_owner  = 0;
    m_locked = 0;
    m_left   = 0;
  endtask

  // Requester the model expects to be offered this cycle, -1 if none.
  function automatic int model_pick();
    if (m_locked) return vld_a[m_owner] ? m_owner : -1;
    for (int k = 1; k <= NA; k++) begin
      if (vld_a[(m_last + k) % NA]) return (m_last + k) % NA;
    end
    return -1;
  endfunction

  function automatic int model_owner(input int p);
    if (m_locked) return m_owner;
    if (p >= 0) return p;
    return m_last;
  endfunction

  function automatic logic [DWA-1:0] model_data(input int p);
    if (p >= 0) return slice_a(p);
    if (m_locked) return slice_a(m_owner);
    return '0;
  endfunction

  task automatic model_step(input bit fifo_ready);
    int p;
    p = model_pick();
    if (m_locked) begin
      if (!vld_a[m_owner]) begin
        m_locked = 0;
      end else if (fifo_ready) begin
        m_left--;
        if (m_left == 0) m_locked = 0;
      end
    end else if (p >= 0 && fifo_ready) begin
      m_last = p;
      if (MBA > 1) begin
        m_locked = 1;
        m_owner  = p;
        m_left   = MBA - 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    vld_a  = '0;
    fgnt_a = 1'b0;
    vld_b  = '0;
    fgnt_b = 1'b0;
    rst    = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    vld_a  = '1;
    fgnt_a = 1'b1;
    vld_b  = '0;
    fgnt_b = 1'b0;
    data_b = '0;
    for (int i = 0; i < NA; i++) set_slice_a(i, rand_word());
    rst = 1'b1;
    #2;
    total++; if (pvld_a !== 1'b0) begin bad++; $display("FAIL reset_pvld got=%b want=0", pvld_a); end
    total++; if (gnt_a !== '0) begin bad++; $display("FAIL reset_grant got=%b want=0000", gnt_a); end
    total++; if (pdata_a !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", pdata_a); end
    total++; if (owner_a !== '0) begin bad++; $display("FAIL reset_owner got=%0d want=0", owner_a); end
    total++; if (locked_a !== 1'b0) begin bad++; $display("FAIL reset_locked got=%b want=0", locked_a); end
    tick();
    total++; if (gnt_a !== '0) begin bad++; $display("FAIL reset_grant_edge got=%b want=0000", gnt_a); end
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    total++; if (gnt_a !== 4'b0001) begin bad++; $display("FAIL reset_first_grant got=%b want=0001", gnt_a); end
    total++; if (pdata_a !== slice_a(0)) begin bad++; $display("FAIL reset_first_data got=%h want=%h", pdata_a, slice_a(0)); end
    tick();
  endtask

  task automatic test_burst_rotate();
    int e;
    do_reset();
    for (int i = 0; i < NA; i++) set_slice_a(i, rand_word());
    vld_a  = '1;
    fgnt_a = 1'b1;
    for (int c = 0; c < 17; c++) begin
      e = (c / MBA) % NA;
      @(negedge clk);
      total++; if (gnt_a !== NA'(1 << e)) begin bad++; $display("FAIL burst_grant c=%0d got=%b want=%b", c, gnt_a, NA'(1 << e)); end
      total++; if (pdata_a !== slice_a(e)) begin bad++; $display("FAIL burst_data c=%0d got=%h want=%h", c, pdata_a, slice_a(e)); end
      total++; if (locked_a !== ((c % MBA) != 0)) begin bad++; $display("FAIL burst_locked c=%0d got=%b want=%b", c, locked_a, (c % MBA) != 0); end
      tick();
      set_slice_a(e, rand_word());
    end
  endtask

  task automatic test_fifo_full();
    do_reset();
    for (int i = 0; i < NA; i++) set_slice_a(i, rand_word());
    vld_a  = 4'b0100;
    fgnt_a = 1'b1;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      total++; if (gnt_a !== 4'b0100) begin bad++; $display("FAIL full_pre b=%0d got=%b want=0100", b, gnt_a); end
      tick();
    end
    vld_a  = 4'b1111;
    fgnt_a = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++; if (gnt_a !== '0) begin bad++; $display("FAIL full_grant c=%0d got=%b want=0000", c, gnt_a); end
      total++; if (locked_a !== 1'b1) begin bad++; $display("FAIL full_locked c=%0d got=%b want=1", c, locked_a); end
      total++; if (owner_a !== 2'd2 || pvld_a !== 1'b1) begin bad++; $display("FAIL full_owner c=%0d got=%0d/%b want=2/1", c, owner_a, pvld_a); end
      tick();
    end
    fgnt_a = 1'b1;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      total++; if (gnt_a !== 4'b0100) begin bad++; $display("FAIL full_post b=%0d got=%b want=0100", b, gnt_a); end
      tick();
    end
    @(negedge clk);
    total++; if (gnt_a !== 4'b1000 || locked_a !== 1'b0) begin bad++; $display("FAIL full_release got=%b/%b want=1000/0", gnt_a, locked_a); end
    tick();
  endtask

  task automatic test_owner_drop();
    do_reset();
    vld_a  = 4'b0110;
    fgnt_a = 1'b1;
    @(negedge clk);
    total++; if (gnt_a !== 4'b0010) begin bad++; $display("FAIL drop_first got=%b want=0010", gnt_a); end
    tick();
    vld_a = 4'b0100;
    @(negedge clk);
    total++; if (gnt_a !== '0 || pvld_a !== 1'b0) begin bad++; $display("FAIL drop_bubble got=%b/%b want=0000/0", gnt_a, pvld_a); end
    total++; if (locked_a !== 1'b1 || owner_a !== 2'd1) begin bad++; $display("FAIL drop_lock got=%b/%0d want=1/1", locked_a, owner_a); end
    tick();
    @(negedge clk);
    total++; if (gnt_a !== 4'b0100 || locked_a !== 1'b0) begin bad++; $display("FAIL drop_next got=%b/%b want=0100/0", gnt_a, locked_a); end
    tick();
  endtask

  task automatic test_np2_wrap();
    logic [DWB-1:0] w;
    do_reset();
    for (int i = 0; i < NB; i++) begin
      w = DWB'($urandom());
      data_b[i*DWB +: DWB] = w;
    end
    vld_b  = '1;
    fgnt_b = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++; if (gnt_b !== NB'(1 << (c % NB))) begin bad++; $display("FAIL wrap_grant c=%0d got=%b want=%b", c, gnt_b, NB'(1 << (c % NB))); end
      total++; if (owner_b !== IWB'(c % NB) || locked_b !== 1'b0) begin bad++; $display("FAIL wrap_owner c=%0d got=%0d/%b want=%0d/0", c, owner_b, locked_b, c % NB); end
      total++; if (pdata_b !== data_b[(c % NB)*DWB +: DWB]) begin bad++; $display("FAIL wrap_data c=%0d got=%h want=%h", c, pdata_b, data_b[(c % NB)*DWB +: DWB]); end
      tick();
    end
    vld_b  = '0;
    fgnt_b = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    for (int i = 0; i < NA; i++) set_slice_a(i, rand_word());
    vld_a  = 4'b1000;
    fgnt_a = 1'b1;
    @(negedge clk);
    total++; if (gnt_a !== 4'b1000) begin bad++; $display("FAIL midrst_first got=%b want=1000", gnt_a); end
    tick();
    vld_a = 4'b1111;
    #1;
    rst = 1'b1;
    #1;
    total++; if (gnt_a !== '0 || pvld_a !== 1'b0) begin bad++; $display("FAIL midrst_quiet got=%b/%b want=0000/0", gnt_a, pvld_a); end
    total++; if (locked_a !== 1'b0) begin bad++; $display("FAIL midrst_lock got=%b want=0", locked_a); end
    tick();
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    total++; if (gnt_a !== 4'b0001 || owner_a !== 2'd0) begin bad++; $display("FAIL midrst_restart got=%b/%0d want=0001/0", gnt_a, owner_a); end
    tick();
  endtask

  task automatic test_random(input int cycles);
    logic [NA-1:0]  gprev;
    logic [NA-1:0]  eg;
    logic [DWA-1:0] ed;
    int p;
    int eo;
    do_reset();
    gprev = '0;
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < NA; i++) begin
        if (!vld_a[i] || gprev[i]) begin
          vld_a[i] = ($urandom_range(0, 99) < 65);
          set_slice_a(i, rand_word());
        end
      end
      fgnt_a = ($urandom_range(0, 3) != 0);
      p  = model_pick();
      eg = (p >= 0 && fgnt_a) ? NA'(1 << p) : '0;
      ed = model_data(p);
      eo = model_owner(p);
      @(negedge clk);
      total++; if (gnt_a !== eg) begin bad++; $display("FAIL rand_grant c=%0d got=%b want=%b", c, gnt_a, eg); end
      total++; if (pvld_a !== (p >= 0)) begin bad++; $display("FAIL rand_pvld c=%0d got=%b want=%b", c, pvld_a, p >= 0); end
      total++; if (pdata_a !== ed) begin bad++; $display("FAIL rand_data c=%0d got=%h want=%h", c, pdata_a, ed); end
      total++; if (owner_a !== IWA'(eo)) begin bad++; $display("FAIL rand_owner c=%0d got=%0d want=%0d", c, owner_a, eo); end
      total++; if (locked_a !== m_locked) begin bad++; $display("FAIL rand_locked c=%0d got=%b want=%b", c, locked_a, m_locked); end
      gprev = eg;
      @(posedge clk);
      model_step(fgnt_a);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_burst_rotate();
    test_fifo_full();
    test_owner_drop();
    test_np2_wrap();
    test_reset_mid_burst();
    test_random(600);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_push_arbiter.md
Name: fifo_push_arbiter

Overview:
- Shares the push side of one FIFO instance among NUM_REQ requesters, using round-robin arbitration with bounded burst locking.
- Each requester sees the same valid/grant handshake as the FIFO push port. The block drives the FIFO push_valid_i/push_data_i and consumes push_grant_o.
- Zero-latency datapath: the selected requester's data is steered combinationally, while arbitration state is registered.

Parameters:
- DATA_WIDTH, 32, payload MSB index; every data bus is DATA_WIDTH+1 bits, matching the FIFO push_data_i.
- NUM_REQ, 4, number of requesters, >=2, any value (power of two not required).
- MAX_BURST, 4, maximum consecutive transfers granted to one owner before rotation, >=1.

Ports:
- clk  in  1  clock, all state on posedge
- rst  in  1  asynchronous reset, active-high
- req_valid_i  in  NUM_REQ  per-requester valid; once raised, held with stable data until granted
- req_data_i  in  NUM_REQ*(DATA_WIDTH+1)  packed requester data; requester i occupies slice [i*(DATA_WIDTH+1) +: DATA_WIDTH+1]
- req_grant_o  out  NUM_REQ  one-hot or zero; bit i high means requester i's beat is accepted this cycle
- push_valid_o  out  1  to FIFO push_valid_i
- push_data_o  out  DATA_WIDTH+1  to FIFO push_data_i
- push_grant_i  in  1  from FIFO push_grant_o (FIFO not full)
- owner_o  out  $clog2(NUM_REQ)  currently selected requester index (candidate or locked owner)
- locked_o  out  1  high while in LOCK state

Behaviour:
- Transfer definition: push_valid_o && push_grant_i in a cycle. Exactly one req_grant_o bit equals this transfer, at the owner_o index.
- Registered state:
  - state_q: ARB or LOCK.
  - last_q: last granted index, reset to NUM_REQ-1 so requester 0 has top priority after reset.
  - owner_q: locked owner.
  - cnt_q: beats in the current burst, width $clog2(MAX_BURST+1).
- Reset (rst high, asynchronous): state_q=ARB, last_q=NUM_REQ-1, owner_q=0, cnt_q=0. While rst is high, push_valid_o=0, req_grant_o=0, push_data_o=0, owner_o=0, locked_o=0, regardless of inputs.
- Reset mid-burst: the lock is dropped immediately and no grant is issued. After release, arbitration restarts from requester 0.
- ARB state:
  - Winner w is the first index with req_valid_i set, searching last_q+1, last_q+2, … modulo NUM_REQ. Wrap is computed modulo NUM_REQ, not 2^k.
  - Outputs: owner_o=w, push_valid_o=|req_valid_i, push_data_o=slice w.
  - No valid requester: push_valid_o=0, owner_o=last_q, push_data_o=0.
  - On transfer: last_q<=w and cnt_q<=1. If MAX_BURST>1, go to LOCK with owner_q<=w; if MAX_BURST==1, stay in ARB.
  - No transfer (FIFO full): stay in ARB and re-evaluate next cycle. A higher-priority requester arriving meanwhile may displace w; this is legal, because w received no grant.
- LOCK state:
  - Outputs come from owner_q only: push_valid_o=req_valid_i[owner_q], push_data_o=slice owner_q, owner_o=owner_q, locked_o=1.
  - Other requesters are never granted while in LOCK.
  - On transfer with cnt_q==MAX_BURST-1: go to ARB, cnt_q<=0. last_q is already owner_q, so the next winner is owner_q+1 onward.
  - On any other transfer: cnt_q<=cnt_q+1.
  - req_valid_i[owner_q]==0: go to ARB next cycle with no transfer, cnt_q<=0. This costs one bubble cycle.
  - FIFO full while owner valid: hold LOCK; the counter does not advance.
- Fairness bound: a continuously valid requester is granted within (NUM_REQ-1)*(MAX_BURST+1) transfer opportunities.
- Combinational paths req_valid_i→push_valid_o and push_grant_i→req_grant_o are intentional. The integrator registers them externally if needed.

Decomposition:
- Shared package fifo_arb_pkg:
  - typedef enum logic {ARB, LOCK} arb_state_e
  - function rr_next(last, NUM_REQ) providing the modulo-NUM_REQ increment
- One sub-module, rr_picker: purely combinational. Inputs are req vector and last index; outputs are winner index and any_valid. It is reusable for a future pop-side scheduler.
- Top level holds the state register, burst counter, data mux and output gating.

Test Plan:
- Reset: rst=1 with req_valid_i=4'b1111 and push_grant_i=1 -> push_valid_o=0 and req_grant_o=0. On release, the first grant goes to requester 0.
- Burst and rotate: all four requesters valid continuously, push_grant_i=1, MAX_BURST=4 -> grants 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0… with push_data_o equal to the granted slice each cycle.
- FIFO full mid-burst:
  - Requester 2 locked after 2 beats, then push_grant_i=0 for 5 cycles -> locked_o stays 1, no grants issued, cnt_q stays 2.
  - After push_grant_i returns, exactly 2 more beats go to requester 2, then the lock releases.
- Owner drops valid: requester 1 locked after 1 beat, req_valid_i[1] falls -> one bubble cycle with no grant, then ARB grants requester 2 if it is valid.
- Non-power-of-two wrap: NUM_REQ=3, MAX_BURST=1, all valid -> grants 0,1,2,0,1,2. Index 3 is never produced on owner_o.
- Reset mid-burst: rst pulsed while requester 3 is locked at cnt 1 -> grants stop asynchronously. After release, the next grant goes to requester 0 (if valid), not 3.
